// File: rtl/ds_led_recver.sv
// ds_led_recver: NAP rx data-stream consumer driving active-low LEDs with hold throttling and sequence checking
module ds_led_recver #(
  parameter int DATA_WIDTH  = 256,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  clear,
  output logic [7:0]            leds,
  output logic [CNT_WIDTH-1:0]  msg_count,
  output logic [CNT_WIDTH-1:0]  seq_err_count,
  output logic                  seq_err
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  typedef enum logic {S_WAIT, S_HOLD} state_t;
  state_t          state;
  logic [HW-1:0]   hold_timer;
  logic [7:0]      expected_seq;
  logic            seq_synced;
  logic            xfer;
  logic            err;
  logic [7:0]      seq;
  logic            unused_hi;
  assign xfer      = rx_valid & rx_ready;
  assign seq       = rx_data[15:8];
  assign err       = xfer & seq_synced & ~clear & (seq != expected_seq);
  assign unused_hi = ^rx_data[DATA_WIDTH-1:16];
  // Handshake FSM: latch the LED pattern on accept, then hold ready low for HOLD_CYCLES cycles
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state      <= S_WAIT;
      hold_timer <= '0;
      rx_ready   <= 1'b0;
      leds       <= 8'hFF;
    end else begin
      if (xfer) leds <= ~rx_data[7:0];
      if (state == S_WAIT) begin
        if (xfer && HOLD_CYCLES > 0) begin
          state      <= S_HOLD;
          hold_timer <= HOLD_INIT;
          rx_ready   <= 1'b0;
        end else rx_ready <= 1'b1;
      end else if (hold_timer == '0) begin
        state    <= S_WAIT;
        rx_ready <= 1'b1;
      end else hold_timer <= hold_timer - 1'b1;
    end
  // Link-health tracking: saturating counters and sequence resync; clear makes a coincident message the first after sync
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      msg_count     <= '0;
      seq_err_count <= '0;
      seq_err       <= 1'b0;
      expected_seq  <= '0;
      seq_synced    <= 1'b0;
    end else begin
      msg_count     <= clear ? CNT_WIDTH'(xfer) : msg_count + CNT_WIDTH'(xfer && msg_count != CNT_MAX);
      seq_err_count <= clear ? '0 : seq_err_count + CNT_WIDTH'(err && seq_err_count != CNT_MAX);
      seq_err       <= err;
      seq_synced    <= clear ? xfer : seq_synced | xfer;
      if (xfer) expected_seq <= seq + 8'd1;
    end
endmodule

// File: tb/tb_ds_led_recver.sv
// tb_ds_led_recver: directed checks of ds_led_recver (default, 4-bit counters, zero-hold instances)
module tb_ds_led_recver;
  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         rx_valid = 1'b0;
  logic [255:0] rx_data = '0;
  logic         clear = 1'b0;
  logic         rdy0, serr0, rdy1, serr1, rdy2, serr2;
  logic [7:0]   leds0, leds1, leds2;
  logic [15:0]  msg0, errc0, msg2, errc2;
  logic [3:0]   msg1, errc1;
  int           vec = 0;
  int           miss = 0;
  int           cyc = 0;
  int           pulses0 = 0;

  ds_led_recver u_dut (.clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_ready(rdy0), .rx_data(rx_data),
    .clear(clear), .leds(leds0), .msg_count(msg0), .seq_err_count(errc0), .seq_err(serr0));
  ds_led_recver #(.CNT_WIDTH(4)) u_sat (.clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_ready(rdy1),
    .rx_data(rx_data), .clear(clear), .leds(leds1), .msg_count(msg1), .seq_err_count(errc1), .seq_err(serr1));
  ds_led_recver #(.HOLD_CYCLES(0)) u_h0 (.clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_ready(rdy2),
    .rx_data(rx_data), .clear(clear), .leds(leds2), .msg_count(msg2), .seq_err_count(errc2), .seq_err(serr2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (serr0) pulses0++;

  task automatic do_reset();
    rx_valid = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // called at a negedge; returns at the negedge after the transfer edge with rx_valid still high
  task automatic send(input logic [7:0] seq, input logic [7:0] pat);
    bit ok = 0;
    rx_data = {{240{1'b1}}, seq, pat};
    rx_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (rdy0) ok = 1;
      @(negedge clk);
    end
    if (!ok) begin
      vec++; miss++;
      $display("FAIL send_timeout seq=%h: no ready within 20 cycles", seq);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vec++; if (rdy0 !== 1'b0) begin miss++; $display("FAIL reset_ready got %b exp 0", rdy0); end
    vec++; if (leds0 !== 8'hFF) begin miss++; $display("FAIL reset_leds got %h exp ff", leds0); end
    vec++; if (msg0 !== 16'd0 || errc0 !== 16'd0) begin miss++; $display("FAIL reset_counts got %0d/%0d exp 0/0", msg0, errc0); end
    vec++; if (serr0 !== 1'b0) begin miss++; $display("FAIL reset_seq_err got %b exp 0", serr0); end
    resetn = 1'b1;
    @(negedge clk);
    vec++; if (rdy0 !== 1'b1) begin miss++; $display("FAIL ready_after_release got %b exp 1", rdy0); end
  endtask

  task automatic test_single();
    int p;
    p = pulses0;
    send(8'h00, 8'hA5);
    rx_valid = 1'b0;
    vec++; if (leds0 !== 8'h5A) begin miss++; $display("FAIL single_leds got %h exp 5a", leds0); end
    vec++; if (msg0 !== 16'd1) begin miss++; $display("FAIL single_msg got %0d exp 1", msg0); end
    for (int i = 0; i < 4; i++) begin
      vec++; if (rdy0 !== 1'b0) begin miss++; $display("FAIL single_hold_low%0d got %b exp 0", i, rdy0); end
      @(negedge clk);
    end
    vec++; if (rdy0 !== 1'b1) begin miss++; $display("FAIL single_ready_back got %b exp 1", rdy0); end
    vec++; if (pulses0 - p !== 0) begin miss++; $display("FAIL single_no_err got %0d pulses exp 0", pulses0 - p); end
  endtask

  task automatic test_back_to_back();
    int t[4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(8'(i), 8'(8'h10 + i));
      t[i] = cyc;
    end
    rx_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      vec++; if (t[i] - t[i-1] !== 5) begin miss++; $display("FAIL b2b_spacing%0d got %0d exp 5", i, t[i] - t[i-1]); end
    end
    vec++; if (msg0 !== 16'd4) begin miss++; $display("FAIL b2b_msg got %0d exp 4", msg0); end
    vec++; if (errc0 !== 16'd0) begin miss++; $display("FAIL b2b_errc got %0d exp 0", errc0); end
  endtask

  task automatic test_seq_err();
    int p;
    do_reset();
    p = pulses0;
    send(8'd0, 8'h01);
    send(8'd1, 8'h02);
    vec++; if (serr0 !== 1'b0) begin miss++; $display("FAIL seq1_no_err got %b exp 0", serr0); end
    send(8'd5, 8'h03);
    vec++; if (serr0 !== 1'b1) begin miss++; $display("FAIL seq5_pulse got %b exp 1", serr0); end
    @(negedge clk);
    vec++; if (serr0 !== 1'b0) begin miss++; $display("FAIL seq5_one_cycle got %b exp 0", serr0); end
    send(8'd6, 8'h04);
    rx_valid = 1'b0;
    vec++; if (serr0 !== 1'b0) begin miss++; $display("FAIL seq6_no_err got %b exp 0", serr0); end
    vec++; if (errc0 !== 16'd1) begin miss++; $display("FAIL seq_errc got %0d exp 1", errc0); end
    vec++; if (pulses0 - p !== 1) begin miss++; $display("FAIL seq_pulses got %0d exp 1", pulses0 - p); end
    repeat (5) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    vec++; if (msg0 !== 16'd0 || errc0 !== 16'd0) begin miss++; $display("FAIL clear_counts got %0d/%0d exp 0/0", msg0, errc0); end
    vec++; if (leds0 !== 8'hFB) begin miss++; $display("FAIL clear_keeps_leds got %h exp fb", leds0); end
    p = pulses0;
    send(8'hFE, 8'h00);
    send(8'hFF, 8'h00);
    send(8'h00, 8'h00);
    rx_valid = 1'b0;
    @(negedge clk);
    vec++; if (errc0 !== 16'd0) begin miss++; $display("FAIL wrap_errc got %0d exp 0", errc0); end
    vec++; if (pulses0 - p !== 0) begin miss++; $display("FAIL wrap_pulses got %0d exp 0", pulses0 - p); end
    vec++; if (msg0 !== 16'd3) begin miss++; $display("FAIL wrap_msg got %0d exp 3", msg0); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 34; i++) begin
      send(8'((i / 2) * 10 + (i % 2)), 8'(i));
      if (i == 9) begin
        vec++; if (msg1 !== 4'd10 || errc1 !== 4'd4) begin miss++; $display("FAIL sat_mid got %0d/%0d exp 10/4", msg1, errc1); end
      end
    end
    rx_valid = 1'b0;
    vec++; if (msg1 !== 4'd15) begin miss++; $display("FAIL sat_msg got %0d exp 15", msg1); end
    vec++; if (errc1 !== 4'd15) begin miss++; $display("FAIL sat_errc got %0d exp 15", errc1); end
  endtask

  task automatic test_hold0();
    do_reset();
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = {{240{1'b0}}, 8'(i), 8'(8'h20 + i)};
      vec++; if (rdy2 !== 1'b1) begin miss++; $display("FAIL h0_ready%0d got %b exp 1", i, rdy2); end
      @(negedge clk);
    end
    rx_valid = 1'b0;
    vec++; if (rdy2 !== 1'b1) begin miss++; $display("FAIL h0_ready_end got %b exp 1", rdy2); end
    vec++; if (msg2 !== 16'd8) begin miss++; $display("FAIL h0_msg got %0d exp 8", msg2); end
    vec++; if (errc2 !== 16'd0) begin miss++; $display("FAIL h0_errc got %0d exp 0", errc2); end
    vec++; if (leds2 !== 8'hD8) begin miss++; $display("FAIL h0_leds got %h exp d8", leds2); end
  endtask

  task automatic test_reset_hold_and_clear();
    bit ok = 0;
    do_reset();
    send(8'h10, 8'h33);
    rx_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    vec++; if (leds0 !== 8'hFF) begin miss++; $display("FAIL rst_hold_leds got %h exp ff", leds0); end
    vec++; if (rdy0 !== 1'b0) begin miss++; $display("FAIL rst_hold_ready got %b exp 0", rdy0); end
    vec++; if (msg0 !== 16'd0 || errc0 !== 16'd0) begin miss++; $display("FAIL rst_hold_counts got %0d/%0d exp 0/0", msg0, errc0); end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    send(8'h37, 8'h0F);
    rx_valid = 1'b0;
    vec++; if (serr0 !== 1'b0 || errc0 !== 16'd0) begin miss++; $display("FAIL rst_first_msg_err got %b/%0d exp 0/0", serr0, errc0); end
    vec++; if (msg0 !== 16'd1 || leds0 !== 8'hF0) begin miss++; $display("FAIL rst_first_msg got %0d/%h exp 1/f0", msg0, leds0); end
    send(8'h50, 8'h00);
    rx_valid = 1'b0;
    vec++; if (errc0 !== 16'd1 || msg0 !== 16'd2) begin miss++; $display("FAIL pre_clear got %0d/%0d exp 1/2", errc0, msg0); end
    rx_data = {{240{1'b0}}, 8'h99, 8'h00};
    rx_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (rdy0) begin ok = 1; clear = 1'b1; end
      @(negedge clk);
    end
    clear = 1'b0;
    rx_valid = 1'b0;
    vec++; if (!ok || msg0 !== 16'd1 || errc0 !== 16'd0 || serr0 !== 1'b0)
      begin miss++; $display("FAIL clear_xfer got ok=%b msg=%0d errc=%0d serr=%b exp 1/1/0/0", ok, msg0, errc0, serr0); end
    send(8'h9A, 8'h00);
    rx_valid = 1'b0;
    vec++; if (serr0 !== 1'b0 || msg0 !== 16'd2) begin miss++; $display("FAIL after_clear got %b/%0d exp 0/2", serr0, msg0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_seq_err();
    test_saturate();
    test_hold0();
    test_reset_hold_and_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
